fp_div_seq: RTL

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_div_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fp_div_seq.sv
// Sequential floating-point divider: packed {sign, exp, frac} operands, truncating restoring divide.
// Latency: special operands 1 cycle after accept, normal operands MAN_W+3 cycles after accept.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   res,
    output logic                   busy
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;   // significand incl. hidden bit
    localparam int REM_W = MAN_W + 2;   // partial remainder, holds up to 2*divisor
    localparam int E_W   = EXP_W + 2;   // signed exponent with room for over/underflow
    localparam int CNT_W = ($clog2(MAN_W + 2) > 5) ? $clog2(MAN_W + 2) : 5;

    localparam logic [E_W-1:0]   BIAS_E   = E_W'(BIAS);
    localparam logic [E_W-1:0]   E_MAX    = E_W'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MAN_W);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_NORM   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             sign_q,  sign_d;
    logic [E_W-1:0]   exp_q,   exp_d;
    logic [SIG_W-1:0] sigb_q,  sigb_d;
    logic [REM_W-1:0] rem_q,   rem_d;
    logic [SIG_W-1:0] quo_q,   quo_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     res_q,   res_d;

    // Operand decode straight from the input ports (only used on accept)
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [SIG_W-1:0] sig_a, sig_b;
    logic             sign_in;
    logic             lt;
    logic [REM_W-1:0] sig_a_adj;
    logic [E_W-1:0]   e_calc;
    logic [W-1:0]     inf_in;

    assign exp_a   = a[W-2:MAN_W];
    assign exp_b   = b[W-2:MAN_W];
    assign sig_a   = {|exp_a, a[MAN_W-1:0]};
    assign sig_b   = {|exp_b, b[MAN_W-1:0]};
    assign sign_in = a[W-1] ^ b[W-1];
    assign inf_in  = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    // Pre-scale the dividend so the quotient always lands in [1, 2); exponent absorbs the shift
    assign lt        = (sig_a < sig_b);
    assign sig_a_adj = lt ? {sig_a, 1'b0} : {1'b0, sig_a};
    assign e_calc    = {2'b00, exp_a} - {2'b00, exp_b} + BIAS_E - E_W'(lt);

    // Final exponent range checks on the stored signed exponent
    logic ovf, unf;
    assign ovf = !exp_q[E_W-1] && (exp_q >= E_MAX);
    assign unf = exp_q[E_W-1] || (exp_q == '0);

    // Restoring step: subtract divisor when it fits, emit quotient bit, shift remainder
    logic             rem_ge;
    logic [REM_W-1:0] rem_sub;

    // Next-state and datapath update for the divider FSM
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sigb_d  = sigb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rem_ge  = (rem_q >= {1'b0, sigb_q});
        rem_sub = rem_ge ? (rem_q - {1'b0, sigb_q}) : rem_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    if ((&exp_a) || (&exp_b)) begin
                        res_d   = inf_in;
                        state_d = ST_DONE;
                    end else if (exp_a == '0) begin
                        res_d   = '0;
                        state_d = ST_DONE;
                    end else if (exp_b == '0) begin
                        res_d   = inf_in;
                        state_d = ST_DONE;
                    end else begin
                        exp_d   = e_calc;
                        sigb_d  = sig_b;
                        rem_d   = sig_a_adj;
                        quo_d   = '0;
                        cnt_d   = CNT_INIT;
                        state_d = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                rem_d = rem_sub << 1;
                quo_d = (quo_q << 1) | SIG_W'(rem_ge);
                if (cnt_q == '0) begin
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_NORM: begin
                // Quotient MSB is the implicit 1; remaining bits are the truncated fraction
                if (ovf) begin
                    res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (unf) begin
                    res_d = '0;
                end else begin
                    res_d = {sign_q, exp_q[EXP_W-1:0], quo_q[MAN_W-1:0]};
                end
                state_d = ST_NORM == state_q ? ST_DONE : state_q;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            sigb_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            sigb_q  <= sigb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res       = res_q;

endmodule
